alu32_core: RTL and testbench



---
 rtl/alu32_core.sv | 112 +++++++++++
 tb/tb_alu32_core.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu32_core.sv
// alu32_core: registered 32-bit ALU for the single-cycle MIPS32 datapath.
// Eight operations chosen by select[2:0]. When select[3] is set, the result is
// forced to zero. Both adder and subtractor carry-outs are registered on every
// cycle, whatever the select code.
// Build option: define ALU32_SRA_EN to make code 110 an arithmetic right shift.
// Without it, code 110 is a logical right shift.
module alu32_core (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] input1,
    input  logic [31:0] input2,
    input  logic [3:0]  select,
    input  logic        carry_in,
    output logic [31:0] result,
    output logic        carry_out_forAdd,
    output logic        carry_out_forSub,
    output logic        zero
);

    // Operation codes for select[2:0].
    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_XOR = 3'b011;
    localparam logic [2:0] OP_NOR = 3'b100;
    localparam logic [2:0] OP_SLL = 3'b101;
    localparam logic [2:0] OP_SRX = 3'b110;
    localparam logic [2:0] OP_SUB = 3'b111;

    logic [31:0] and_vec;
    logic [31:0] or_vec;
    logic [31:0] xor_vec;
    logic [31:0] nor_vec;
    logic [32:0] add_sum;
    logic [32:0] sub_sum;
    logic [4:0]  shamt;
    logic [31:0] sll_val;
    logic [31:0] srx_val;

    logic [31:0] result_next;
    logic        zero_next;
    logic [31:0] result_reg;
    logic        carry_add_reg;
    logic        carry_sub_reg;
    logic        zero_reg;

    // Bitwise logic slices.
    genvar gi;
    generate
        for (gi = 0; gi < 32; gi++) begin : g_bit
            assign and_vec[gi] = input1[gi] & input2[gi];
            assign or_vec[gi]  = input1[gi] | input2[gi];
            assign xor_vec[gi] = input1[gi] ^ input2[gi];
            assign nor_vec[gi] = ~(input1[gi] | input2[gi]);
        end
    endgenerate

    // Keep the adder and subtractor separate so each has its own carry-out.
    // carry_in feeds only the adder. An unknown carry_in therefore cannot
    // reach SUB or its carry.
    assign add_sum = {1'b0, input1} + {1'b0, input2} + {32'd0, carry_in};
    assign sub_sum = {1'b0, input1} + {1'b0, ~input2} + 33'd1;

    // Only the low five bits of input2 count as a shift amount.
    assign shamt   = input2[4:0];
    assign sll_val = input1 << shamt;
`ifdef ALU32_SRA_EN
    assign srx_val = $unsigned($signed(input1) >>> shamt);
`else
    assign srx_val = input1 >> shamt;
`endif

    // Select the operation result. Reserved codes (select[3]) give zero.
    always_comb begin
        result_next = 32'd0;
        if (!select[3]) begin
            case (select[2:0])
                OP_AND: result_next = and_vec;
                OP_OR:  result_next = or_vec;
                OP_ADD: result_next = add_sum[31:0];
                OP_XOR: result_next = xor_vec;
                OP_NOR: result_next = nor_vec;
                OP_SLL: result_next = sll_val;
                OP_SRX: result_next = srx_val;
                OP_SUB: result_next = sub_sum[31:0];
            endcase
        end
        zero_next = (result_next == 32'd0);
    end

    // Output registers. Asynchronous reset clears them and drops the
    // operation currently in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_reg    <= 32'd0;
            carry_add_reg <= 1'b0;
            carry_sub_reg <= 1'b0;
            zero_reg      <= 1'b0;
        end else begin
            result_reg    <= result_next;
            carry_add_reg <= add_sum[32];
            carry_sub_reg <= sub_sum[32];
            zero_reg      <= zero_next;
        end
    end

    assign result           = result_reg;
    assign carry_out_forAdd = carry_add_reg;
    assign carry_out_forSub = carry_sub_reg;
    assign zero             = zero_reg;

endmodule

// File: tb/tb_alu32_core.sv
// Self-checking bench for alu32_core.
// It runs three kinds of test:
//   - a table of directed vectors;
//   - hand-written reset sequences;
//   - random operations checked against an arithmetic reference model.
// Code 110 expectations follow ALU32_SRA_EN when it is defined.
module tb_alu32_core;

    logic        clk;
    logic        rst_n;
    logic [31:0] input1;
    logic [31:0] input2;
    logic [3:0]  select;
    logic        carry_in;
    logic [31:0] result;
    logic        carry_out_forAdd;
    logic        carry_out_forSub;
    logic        zero;

    int checks;
    int failures;

    alu32_core dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .input1           (input1),
        .input2           (input2),
        .select           (select),
        .carry_in         (carry_in),
        .result           (result),
        .carry_out_forAdd (carry_out_forAdd),
        .carry_out_forSub (carry_out_forSub),
        .zero             (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One directed vector. When chk_c is 0, the carries come from the model.
    typedef struct {
        string       name;
        logic [3:0]  sel;
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic [31:0] exp_res;
        logic        exp_zero;
        logic        chk_c;
        logic        exp_cadd;
        logic        exp_csub;
    } vec_t;

    // Reference model built from the operation rules using plain arithmetic.
    function automatic logic [31:0] model_result(input logic [3:0] sel, input logic [31:0] a,
                                                 input logic [31:0] b, input logic cin);
        int unsigned s;
        logic [63:0] wide;
        logic [31:0] fill;
        s = int'(b % 32);
        if (sel >= 4'd8) return 32'd0;
        case (sel)
            4'd0: return a & b;
            4'd1: return a | b;
            4'd2: begin
                wide = 64'(a) + 64'(b) + 64'(cin);
                return wide[31:0];
            end
            4'd3: return a ^ b;
            4'd4: return ~(a | b);
            4'd5: begin
                wide = 64'(a) * (64'd1 << s);
                return wide[31:0];
            end
            4'd6: begin
`ifdef ALU32_SRA_EN
                fill = a[31] ? ~(32'hFFFF_FFFF >> s) : 32'd0;
`else
                fill = 32'd0;
`endif
                return (a / (32'd1 << s)) | fill;
            end
            default: begin
                wide = 64'(a) + 64'h1_0000_0000 - 64'(b);
                return wide[31:0];
            end
        endcase
    endfunction

    // ADD carries out when the true sum reaches 2^32.
    function automatic logic model_cadd(input logic [31:0] a, input logic [31:0] b, input logic cin);
        return (64'(a) + 64'(b) + 64'(cin)) >= 64'h1_0000_0000;
    endfunction

    // SUB reports "no borrow" exactly when a >= b (unsigned).
    function automatic logic model_csub(input logic [31:0] a, input logic [31:0] b);
        return a >= b;
    endfunction

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0b expected %0b", name, act, exp);
        end
    endtask

    // Drive at negedge, let one rising edge capture, then sample 1 ns later.
    task automatic run_op(input logic [3:0] sel, input logic [31:0] a,
                          input logic [31:0] b, input logic cin);
        @(negedge clk);
        select   = sel;
        input1   = a;
        input2   = b;
        carry_in = cin;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string name, input logic [31:0] er, input logic ez,
                             input logic eca, input logic ecs);
        check32({name, ".result"}, result, er);
        check1({name, ".zero"}, zero, ez);
        check1({name, ".cadd"}, carry_out_forAdd, eca);
        check1({name, ".csub"}, carry_out_forSub, ecs);
        $display("op %-14s sel=%h res=0x%08h z=%0b ca=%0b cs=%0b", name, select, result, zero,
                 carry_out_forAdd, carry_out_forSub);
    endtask

    vec_t vecs[$];
    logic [31:0] sr4_exp;
    logic [31:0] sr31_exp;

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        input1   = 32'd0;
        input2   = 32'd0;
        select   = 4'd0;
        carry_in = 1'b0;

`ifdef ALU32_SRA_EN
        sr4_exp  = 32'hFFFF_FFFF;
        sr31_exp = 32'hFFFF_FFFF;
`else
        sr4_exp  = 32'h0FFF_FFFF;
        sr31_exp = 32'h0000_0001;
`endif
        //          name          sel    a             b             cin   exp_res       z     chk   ca    cs
        vecs.push_back('{"and_zero",  4'd0, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{"or",        4'd1, 32'h5AD7_6D6B, 32'h30D6_4F61, 1'b0, 32'h7AD7_6F6B, 1'b0, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{"add_ff",    4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b1, 1'b1, 1'b1});
        vecs.push_back('{"add_cin",   4'd2, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 1'b1, 1'b1, 1'b1});
        vecs.push_back('{"sub_neg",   4'd7, 32'h0000_0005, 32'h0000_0007, 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{"sub_pos",   4'd7, 32'h0000_0007, 32'h0000_0005, 1'b1, 32'h0000_0002, 1'b0, 1'b1, 1'b0, 1'b1});
        vecs.push_back('{"nor",       4'd4, 32'hFFFF_FFE0, 32'h0000_001F, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{"xor",       4'd3, 32'hC7F7_BBBF, 32'h8811_0554, 1'b0, 32'h4FE6_BEEB, 1'b0, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{"sll3",      4'd5, 32'h8000_0110, 32'h0000_0003, 1'b0, 32'h0000_0880, 1'b0, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{"sll0_hi",   4'd5, 32'h1234_5678, 32'hFFFF_FFE0, 1'b0, 32'h1234_5678, 1'b0, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{"sr4",       4'd6, 32'hFFFF_FFFF, 32'h0000_0004, 1'b0, sr4_exp,       1'b0, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{"sr4_hi",    4'd6, 32'hFFFF_FFFF, 32'hABCD_EF04, 1'b0, sr4_exp,       1'b0, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{"sr31",      4'd6, 32'hFFFF_FFFF, 32'h0000_001F, 1'b0, sr31_exp,      1'b0, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{"sr_pos31",  4'd6, 32'h4000_0000, 32'h0000_001E, 1'b0, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{"reserved",  4'hA, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 32'h0000_0000, 1'b1, 1'b1, 1'b1, 1'b1});
        vecs.push_back('{"reserved2", 4'hF, 32'h0000_0005, 32'h0000_0007, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b0, 1'b0});

        // Outputs held at zero while reset is active, even across clock edges.
        repeat (2) @(posedge clk);
        #1;
        check_all("reset_hold", 32'd0, 1'b0, 1'b0, 1'b0);

        // The first capture happens at the first rising edge after release.
        @(negedge clk);
        rst_n    = 1'b1;
        select   = 4'd1;
        input1   = 32'h0000_00F0;
        input2   = 32'h0000_000F;
        check32("pre_capture.result", result, 32'd0);
        @(posedge clk);
        #1;
        check_all("first_cap", 32'h0000_00FF, 1'b0, 1'b0, 1'b1);

        // Directed table.
        for (int i = 0; i < vecs.size(); i++) begin
            run_op(vecs[i].sel, vecs[i].a, vecs[i].b, vecs[i].cin);
            check_all(vecs[i].name, vecs[i].exp_res, vecs[i].exp_zero,
                      vecs[i].chk_c ? vecs[i].exp_cadd : model_cadd(vecs[i].a, vecs[i].b, vecs[i].cin),
                      vecs[i].chk_c ? vecs[i].exp_csub : model_csub(vecs[i].a, vecs[i].b));
        end

        // Mid-stream asynchronous reset clears outputs between edges and
        // drops the operation in flight.
        run_op(4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        check_all("pre_async", 32'hFFFF_FFFE, 1'b0, 1'b1, 1'b1);
        #1;
        rst_n = 1'b0;
        #1;
        check_all("async_rst", 32'd0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check_all("async_hold", 32'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_all("post_async", 32'hFFFF_FFFE, 1'b0, 1'b1, 1'b1);

        // Random operations against the reference model. Operands are biased
        // toward extreme values now and then.
        for (int n = 0; n < 400; n++) begin
            logic [3:0]  rs;
            logic [31:0] ra;
            logic [31:0] rb;
            logic        rc;
            rs = 4'($urandom_range(15, 0));
            ra = $urandom;
            rb = $urandom;
            rc = 1'($urandom_range(1, 0));
            if ($urandom_range(7, 0) == 0) ra = 32'hFFFF_FFFF;
            if ($urandom_range(7, 0) == 0) rb = ($urandom_range(1, 0) == 1) ? 32'hFFFF_FFFF : ra;
            if ($urandom_range(3, 0) == 0) ra[31] = 1'b1;
            run_op(rs, ra, rb, rc);
            check_all($sformatf("rnd%0d", n), model_result(rs, ra, rb, rc),
                      model_result(rs, ra, rb, rc) == 32'd0,
                      model_cadd(ra, rb, rc), model_csub(ra, rb));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
